mem_fill_responder: RTL and testbench

//  Memory-side responder for cache line fills and word writes issued by the pipeline's cache controller.
//  It accepts one read request at a time.

---
 rtl/mem_fill_responder_if.sv | 30 +++
 rtl/mem_fill_responder.sv | 137 +++++++++++++
 tb/tb_mem_fill_responder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_fill_responder_if.sv
// Request/write/response bundle between cache miss logic and mem_fill_responder.
// master = cache controller side, slave = memory responder side.
interface mem_fill_responder_if;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        resp_valid;
  logic [15:0] resp_addr;
  logic [15:0] resp_data;
  logic        resp_last;

  modport master (
    output req_valid, req_addr,
    output wr_en, wr_addr, wr_data,
    input  req_ready,
    input  resp_valid, resp_addr,
    input  resp_data, resp_last
  );

  modport slave (
    input  req_valid, req_addr,
    input  wr_en, wr_addr, wr_data,
    output req_ready,
    output resp_valid, resp_addr,
    output resp_data, resp_last
  );
endinterface

// File: rtl/mem_fill_responder.sv
// Memory stand-in: line fills after a fixed latency as a word burst,
// single-word writes complete on acceptance. MEM_AW must be <= 14.
module mem_fill_responder #(
  parameter int LATENCY = 4,
  parameter int BURST   = 8,
  parameter int MEM_AW  = 10
) (
  input logic clk,
  input logic rst,
  mem_fill_responder_if.slave bus
);

  localparam int LB = $clog2(2 * BURST);
  localparam int IW = $clog2(BURST) + 1;
  localparam int CW = 4;
  localparam logic [15:0] LMASK = 16'(2 * BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [15:0]     r_base;
  logic [15:0]     w_base;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx;
  logic            w_idle;
  logic            w_accept;
  logic            w_emit;
  logic            w_wr;
  logic [15:0]     w_line;
  logic [15:0]     w_addr;
  logic [MEM_AW-1:0] w_mem_idx;
  logic            r_resp_valid;
  logic            r_resp_last;
  logic [15:0]     r_resp_addr;
  logic [15:0]     r_resp_data;
  logic [15:0]     r_mem [2**MEM_AW];
  logic            w_unused;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle & bus.req_valid & ~bus.wr_en;
  assign w_wr      = w_idle & bus.wr_en & ~rst;
  assign w_line    = bus.req_addr & ~LMASK;
  assign w_addr    = w_base + 16'({w_idx, 1'b0});
  assign w_mem_idx = w_addr[MEM_AW:1];
  assign w_unused  = ^{bus.req_addr[LB-1:0],
                       bus.wr_addr[0],
                       bus.wr_addr[15:MEM_AW+1]};

  // next state, counters and which word (if any) to launch this edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_base      = r_base;
    w_idx       = r_idx;
    w_emit      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_base    = w_line;
          w_idx     = '0;
          w_cnt_nxt = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            w_state_nxt = S_BURST;
            w_emit      = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_BURST;
          w_emit      = 1'b1;
        end
      end
      S_BURST: begin
        if (r_idx == IW'(BURST)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_emit = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state, counters and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_base       <= '0;
      r_idx        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_base  <= w_base;
      if (w_emit) begin
        r_idx        <= w_idx + IW'(1);
        r_resp_valid <= 1'b1;
        r_resp_last  <= (w_idx == IW'(BURST - 1));
        r_resp_addr  <= w_addr;
        r_resp_data  <= r_mem[w_mem_idx];
      end else begin
        r_idx        <= w_idx;
        r_resp_valid <= 1'b0;
        r_resp_last  <= 1'b0;
      end
    end
  end

  // backing word array, written only while idle
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[bus.wr_addr[MEM_AW:1]] <= bus.wr_data;
    end
  end

  assign bus.req_ready  = w_idle;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_last  = r_resp_last;
  assign bus.resp_addr  = r_resp_addr;
  assign bus.resp_data  = r_resp_data;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: two configurations, a cycle-level reference
// model checked every cycle, plus directed literal expectations.
module tb_mem_fill_responder;

  localparam int AW = 10;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  mem_fill_responder_if ifa ();
  mem_fill_responder_if ifb ();

  assign ifa.req_valid = req_valid;
  assign ifa.req_addr  = req_addr;
  assign ifa.wr_en     = wr_en;
  assign ifa.wr_addr   = wr_addr;
  assign ifa.wr_data   = wr_data;
  assign ifb.req_valid = req_valid;
  assign ifb.req_addr  = req_addr;
  assign ifb.wr_en     = wr_en;
  assign ifb.wr_addr   = wr_addr;
  assign ifb.wr_data   = wr_data;

  mem_fill_responder #(
    .LATENCY(4), .BURST(8), .MEM_AW(AW)
  ) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  mem_fill_responder #(
    .LATENCY(1), .BURST(2), .MEM_AW(AW)
  ) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  logic        rr [2];
  logic        rv [2];
  logic        rl [2];
  logic [15:0] ra [2];
  logic [15:0] rd [2];

  assign rr[0] = ifa.req_ready;
  assign rv[0] = ifa.resp_valid;
  assign rl[0] = ifa.resp_last;
  assign ra[0] = ifa.resp_addr;
  assign rd[0] = ifa.resp_data;
  assign rr[1] = ifb.req_ready;
  assign rv[1] = ifb.resp_valid;
  assign rl[1] = ifb.resp_last;
  assign ra[1] = ifb.resp_addr;
  assign rd[1] = ifb.resp_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int L_ [2] = '{4, 1};
  int B_ [2] = '{8, 2};
  int acc [2] = '{-1, -1};
  logic [15:0] mbase [2];
  logic [15:0] hold_a [2];
  logic [15:0] hold_d [2];
  logic [15:0] mem_m [2][1024];
  bit mon = 0;

  task automatic chk(input string nm, input int d,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)",
               nm, d, act, exp, cyc);
    end
  endtask

  function automatic bit busy_f(input int d);
    return acc[d] >= 0 && cyc > acc[d] &&
           cyc < acc[d] + L_[d] + B_[d];
  endfunction

  // reference: a fill accepted in cycle a returns word i in cycle a+L+i
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit          bz;
      bit          v;
      bit          el;
      int          i;
      logic [15:0] ea;
      logic [15:0] ed;
      bz = busy_f(d);
      v  = acc[d] >= 0 && cyc >= acc[d] + L_[d] &&
           cyc < acc[d] + L_[d] + B_[d];
      if (v) begin
        i  = cyc - acc[d] - L_[d];
        ea = mbase[d] + 16'(2 * i);
        ed = mem_m[d][ea[AW:1]];
        el = (i == B_[d] - 1);
        hold_a[d] = ea;
        hold_d[d] = ed;
      end else begin
        ea = hold_a[d];
        ed = hold_d[d];
        el = 1'b0;
      end
      if (mon) begin
        chk("m_ready", d, 16'(rr[d]), 16'(!bz));
        chk("m_valid", d, 16'(rv[d]), 16'(v));
        chk("m_last",  d, 16'(rl[d]), 16'(el));
        chk("m_addr",  d, ra[d], ea);
        chk("m_data",  d, rd[d], ed);
      end
      if (rst) begin
        acc[d]    = -1;
        hold_a[d] = '0;
        hold_d[d] = '0;
      end else if (!bz) begin
        if (wr_en) begin
          mem_m[d][wr_addr[AW:1]] = wr_data;
        end else if (req_valid) begin
          acc[d]   = cyc;
          mbase[d] = req_addr & ~16'(2 * B_[d] - 1);
        end
      end
    end
    if (rst) mon = 1;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  int a;
  int lasts;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 0, 16'(rr[0]), 16'd1);
    chk("rst_valid", 0, 16'(rv[0]), 16'd0);
    chk("rst_last",  0, 16'(rl[0]), 16'd0);
    chk("rst_addr",  0, ra[0], 16'h0000);
    chk("rst_data",  0, rd[0], 16'h0000);
    chk("rst_valid", 1, 16'(rv[1]), 16'd0);

    for (int k = 0; k < 1024; k++) begin
      logic [9:0] ix;
      ix = 10'(k);
      wr_en   = 1'b1;
      wr_addr = {5'($urandom), ix, 1'($urandom)};
      wr_data = 16'($urandom);
      step();
    end

    for (int k = 0; k < 8; k++) begin
      wr_en   = 1'b1;
      wr_addr = 16'h0020 + 16'(2 * k);
      wr_data = 16'hA000 + 16'(k);
      step();
    end
    wr_en = 1'b0;
    req_valid = 1'b1;
    req_addr = 16'h0026;
    a = cyc;
    step();
    req_valid = 1'b0;
    chk("fill_busy",   0, 16'(rr[0]), 16'd0);
    chk("b_fill_v0",   1, 16'(rv[1]), 16'd1);
    chk("b_fill_a0",   1, ra[1], 16'h0024);
    chk("b_fill_d0",   1, rd[1], 16'hA002);
    wait_to(a + 2);
    chk("b_fill_last", 1, 16'(rl[1]), 16'd1);
    chk("b_fill_d1",   1, rd[1], 16'hA003);
    wait_to(a + 3);
    chk("fill_v_pre",  0, 16'(rv[0]), 16'd0);
    chk("b_ready",     1, 16'(rr[1]), 16'd1);
    wait_to(a + 4);
    chk("fill_v_first", 0, 16'(rv[0]), 16'd1);
    chk("fill_a_first", 0, ra[0], 16'h0020);
    chk("fill_d_first", 0, rd[0], 16'hA000);
    wait_to(a + 10);
    chk("fill_nolast", 0, 16'(rl[0]), 16'd0);
    wait_to(a + 11);
    chk("fill_last",   0, 16'(rl[0]), 16'd1);
    chk("fill_a_last", 0, ra[0], 16'h002E);
    chk("fill_d_last", 0, rd[0], 16'hA007);
    wait_to(a + 12);
    chk("fill_ready",  0, 16'(rr[0]), 16'd1);
    chk("fill_v_end",  0, 16'(rv[0]), 16'd0);
    chk("fill_hold",   0, rd[0], 16'hA007);

    wait_to(a + 15);
    wr_en = 1'b1;
    wr_addr = 16'h0062;
    wr_data = 16'hBEEF;
    req_valid = 1'b1;
    req_addr = 16'h0060;
    a = cyc;
    step();
    wr_en = 1'b0;
    chk("coll_noacc", 0, 16'(rr[0]), 16'd1);
    step();
    req_valid = 1'b0;
    chk("coll_acc", 0, 16'(rr[0]), 16'd0);
    wait_to(a + 3);
    chk("b_coll_d", 1, rd[1], 16'hBEEF);
    wait_to(a + 6);
    chk("coll_a", 0, ra[0], 16'h0062);
    chk("coll_d", 0, rd[0], 16'hBEEF);

    wait_to(a + 20);
    req_valid = 1'b1;
    req_addr = 16'h0040;
    a = cyc;
    step();
    req_addr = 16'h0050;
    lasts = 0;
    for (int t = a + 1; t <= a + 30; t++) begin
      wait_to(t);
      if (t == a + 13) req_valid = 1'b0;
      if (t == a + 15) chk("b2b_gap", 0, 16'(rv[0]), 16'd0);
      if (t == a + 16) begin
        chk("b2b_v2", 0, 16'(rv[0]), 16'd1);
        chk("b2b_a2", 0, ra[0], 16'h0050);
      end
      lasts += int'(rl[0]);
    end
    chk("b2b_lasts", 0, 16'(lasts), 16'd2);

    wait_to(cyc + 10);
    req_valid = 1'b1;
    req_addr = 16'h0100;
    a = cyc;
    step();
    req_valid = 1'b0;
    wait_to(a + 6);
    chk("abort_pre_v", 0, 16'(rv[0]), 16'd1);
    chk("abort_pre_a", 0, ra[0], 16'h0104);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_v", 0, 16'(rv[0]), 16'd0);
    chk("abort_l", 0, 16'(rl[0]), 16'd0);
    chk("abort_a", 0, ra[0], 16'h0000);
    req_valid = 1'b1;
    req_addr = 16'h0110;
    a = cyc;
    step();
    req_valid = 1'b0;
    wait_to(a + 4);
    chk("rearm_a0", 0, ra[0], 16'h0110);
    wait_to(a + 11);
    chk("rearm_last", 0, 16'(rl[0]), 16'd1);
    chk("rearm_a7", 0, ra[0], 16'h011E);

    wait_to(a + 15);
    wr_en = 1'b1;
    wr_addr = 16'h07F0;
    wr_data = 16'h5A5A;
    a = cyc;
    step();
    wr_en = 1'b0;
    req_valid = 1'b1;
    req_addr = 16'hFFF8;
    step();
    req_valid = 1'b0;
    wait_to(a + 5);
    chk("wrap_a0", 0, ra[0], 16'hFFF0);
    chk("wrap_d0", 0, rd[0], 16'h5A5A);
    wait_to(a + 12);
    chk("wrap_a7", 0, ra[0], 16'hFFFE);
    chk("wrap_last", 0, 16'(rl[0]), 16'd1);

    wait_to(a + 16);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(99) == 0) begin
        rst = 1'b1;
        wr_en = 1'b0;
        req_valid = 1'b0;
      end else begin
        rst = 1'b0;
        wr_en = ($urandom_range(9) < 3);
        req_valid = ($urandom_range(9) < 4);
      end
      req_addr = 16'($urandom);
      wr_addr = 16'($urandom);
      wr_data = 16'($urandom);
      step();
    end
    rst = 1'b0;
    wr_en = 1'b0;
    req_valid = 1'b0;
    wait_to(cyc + 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
